mul: RTL and testbench

Iterative 32×32 integer multiplier in the execute stage, sitting beside the divider and sharing its issue-side contract: single-cycle enable pulse with operands and destination address, a registered stall while busy, and a one-cycle result-valid pulse. It is the multiplicative counterpart of the divider. It computes the unsigned product of operand magnitudes two multiplier bits per cycle, terminates early on short multipliers, and applies sign correction at the end. It supports the low-word product and the signed and unsigned high-word products.

---
 rtl/mul.sv | 183 ++++++++++++++++++
 tb/tb_mul.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul.sv
// mul: iterative 32x32 integer multiplier for the execute stage.
//
// Shares the divider's issue contract: a single-cycle issue pulse carrying
// operands and a destination register, a registered stall while an operation
// is in flight, and a one-cycle result-valid pulse.
//
// The unsigned product of the operand magnitudes is accumulated two
// multiplier bits per cycle (radix-4). The loop ends as soon as the remaining
// multiplier bits are all zero, so short multipliers finish early. The sign
// is applied once, in the final cycle.
//
// Ports:
//   clk                clock, all state updates on the rising edge
//   rst                synchronous active-high reset
//   mul_en_in          issue pulse, sampled only while idle
//   mul_op             0 = low word of the product, 1 = high word
//   mul_sign           1 = signed operands, 0 = unsigned operands
//   mul_sr0            multiplicand
//   mul_sr1            multiplier
//   mul_addr_in        destination register of the issued operation
//   mul_flush          abort the in-flight operation (blocks issue when idle)
//   mul_en_out         result-valid pulse, one cycle wide
//   stall_because_mul  high while an accepted operation is in flight
//   mul_result         result, meaningful only while mul_en_out is high
//   mul_addr_out       destination register of the delivered result
module mul (
  input  logic        clk,
  input  logic        rst,
  input  logic        mul_en_in,
  input  logic        mul_op,
  input  logic        mul_sign,
  input  logic [31:0] mul_sr0,
  input  logic [31:0] mul_sr1,
  input  logic [4:0]  mul_addr_in,
  input  logic        mul_flush,
  output logic        mul_en_out,
  output logic        stall_because_mul,
  output logic [31:0] mul_result,
  output logic [4:0]  mul_addr_out
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StFin  = 2'd2
  } state_e;

  state_e      state;

  // Datapath registers. The multiplicand is held at 64 bits because it is
  // shifted left by two every cycle and must not lose bits.
  logic [63:0] mcand;
  logic [31:0] mplier;
  logic [63:0] prod;
  logic        neg;
  logic        op_hi;
  logic [4:0]  addr_lat;

  // Operand magnitudes. 0x80000000 negates to itself, which is the correct
  // magnitude once it is treated as a 32-bit unsigned value.
  logic [31:0] mag0;
  logic [31:0] mag1;
  logic        zero_operand;
  logic        neg_in;

  always_comb begin
    mag0 = mul_sr0;
    mag1 = mul_sr1;
    if (mul_sign && mul_sr0[31]) begin
      mag0 = ~mul_sr0 + 32'd1;
    end
    if (mul_sign && mul_sr1[31]) begin
      mag1 = ~mul_sr1 + 32'd1;
    end
    zero_operand = (mul_sr0 == 32'd0) || (mul_sr1 == 32'd0);
    neg_in       = mul_sign & (mul_sr0[31] ^ mul_sr1[31]);
  end

  // Radix-4 partial product: multiplicand times the low two multiplier bits.
  logic [63:0] partial;
  logic [63:0] prod_next;
  logic        last_step;

  always_comb begin
    partial = 64'd0;
    case (mplier[1:0])
      2'd0: partial = 64'd0;
      2'd1: partial = mcand;
      2'd2: partial = mcand << 1;
      2'd3: partial = mcand + (mcand << 1);
      default: partial = 64'd0;
    endcase
    prod_next = prod + partial;
    // The step being taken now is the last one if nothing is left above it.
    last_step = (mplier[31:2] == 30'd0);
  end

  // Sign-corrected 64-bit product, formed from the completed accumulator.
  logic [63:0] signed_prod;

  always_comb begin
    signed_prod = prod;
    if (neg) begin
      signed_prod = ~prod + 64'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= StIdle;
      mcand             <= 64'd0;
      mplier            <= 32'd0;
      prod              <= 64'd0;
      neg               <= 1'b0;
      op_hi             <= 1'b0;
      addr_lat          <= 5'd0;
      mul_en_out        <= 1'b0;
      stall_because_mul <= 1'b0;
      mul_result        <= 32'd0;
      mul_addr_out      <= 5'd0;
    end else begin
      case (state)
        StIdle: begin
          mul_en_out <= 1'b0;
          mul_result <= 32'd0;
          if (mul_flush) begin
            // Flush wins over a same-cycle issue: nothing is accepted.
            stall_because_mul <= 1'b0;
          end else if (mul_en_in) begin
            if (zero_operand) begin
              // Product is trivially zero; answer next cycle without stalling.
              mul_addr_out <= mul_addr_in;
              mul_en_out   <= 1'b1;
            end else begin
              mcand             <= {32'd0, mag0};
              mplier            <= mag1;
              prod              <= 64'd0;
              neg               <= neg_in;
              op_hi             <= mul_op;
              addr_lat          <= mul_addr_in;
              stall_because_mul <= 1'b1;
              state             <= StBusy;
            end
          end
        end

        StBusy: begin
          mul_en_out <= 1'b0;
          if (mul_flush) begin
            stall_because_mul <= 1'b0;
            state             <= StIdle;
          end else begin
            prod   <= prod_next;
            mcand  <= mcand << 2;
            mplier <= mplier >> 2;
            if (last_step) begin
              state <= StFin;
            end
          end
        end

        StFin: begin
          stall_because_mul <= 1'b0;
          state             <= StIdle;
          if (mul_flush) begin
            mul_en_out <= 1'b0;
          end else begin
            mul_result   <= op_hi ? signed_prod[63:32] : signed_prod[31:0];
            mul_addr_out <= addr_lat;
            mul_en_out   <= 1'b1;
          end
        end

        default: begin
          stall_because_mul <= 1'b0;
          mul_en_out        <= 1'b0;
          state             <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul.sv
module tb_mul;

  logic        clk;
  logic        rst;
  logic        mul_en_in;
  logic        mul_op;
  logic        mul_sign;
  logic [31:0] mul_sr0;
  logic [31:0] mul_sr1;
  logic [4:0]  mul_addr_in;
  logic        mul_flush;
  logic        mul_en_out;
  logic        stall_because_mul;
  logic [31:0] mul_result;
  logic [4:0]  mul_addr_out;

  int checks;
  int failures;

  mul dut (
    .clk               (clk),
    .rst               (rst),
    .mul_en_in         (mul_en_in),
    .mul_op            (mul_op),
    .mul_sign          (mul_sign),
    .mul_sr0           (mul_sr0),
    .mul_sr1           (mul_sr1),
    .mul_addr_in       (mul_addr_in),
    .mul_flush         (mul_flush),
    .mul_en_out        (mul_en_out),
    .stall_because_mul (stall_because_mul),
    .mul_result        (mul_result),
    .mul_addr_out      (mul_addr_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: full 64-bit product via plain multiplication.
  function automatic logic [31:0] ref_result(input logic s, input logic o,
                                             input logic [31:0] a, input logic [31:0] b);
    logic [63:0] x;
    logic [63:0] y;
    logic [63:0] p;
    x = s ? {{32{a[31]}}, a} : {32'd0, a};
    y = s ? {{32{b[31]}}, b} : {32'd0, b};
    p = x * y;
    return o ? p[63:32] : p[31:0];
  endfunction

  // Edges from issue to result pulse: 0 for a zero operand, else k+1.
  function automatic int ref_latency(input logic s, input logic [31:0] a,
                                     input logic [31:0] b);
    logic [31:0] m;
    int bl;
    if (a == 32'd0 || b == 32'd0) return 0;
    m = (s && b[31]) ? (32'd0 - b) : b;
    bl = 0;
    for (int i = 0; i < 32; i++) if (m[i]) bl = i + 1;
    return (bl + 1) / 2 + 1;
  endfunction

  // Drives one issue (caller is just after an edge) and waits for the pulse.
  // Returns at the sample where mul_en_out is high, or after a bounded wait.
  task automatic run_op(input logic s, input logic o, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] ad,
                        output logic got, output logic [31:0] res,
                        output logic [4:0] rad, output int lat, output int stalls);
    mul_sign    = s;
    mul_op      = o;
    mul_sr0     = a;
    mul_sr1     = b;
    mul_addr_in = ad;
    mul_en_in   = 1'b1;
    @(posedge clk); #1;
    mul_en_in = 1'b0;
    got = 1'b0; res = 32'd0; rad = 5'd0; lat = -1; stalls = 0;
    for (int n = 0; n < 40; n++) begin
      if (mul_en_out) begin
        got = 1'b1; res = mul_result; rad = mul_addr_out; lat = n;
        break;
      end
      if (stall_because_mul) stalls++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({mul_en_out, stall_because_mul, mul_result, mul_addr_out} !== 39'd0) begin
      failures++;
      $display("FAIL reset_outputs: got en=%b stall=%b res=%h addr=%0d, want all 0",
               mul_en_out, stall_because_mul, mul_result, mul_addr_out);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({mul_en_out, stall_because_mul} !== 2'b00) begin
      failures++;
      $display("FAIL idle_after_reset: got en=%b stall=%b, want 0 0",
               mul_en_out, stall_because_mul);
    end
  endtask

  // One directed operation with every property checked against the model.
  task automatic test_directed(input string name, input logic s, input logic o,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] ad);
    logic got; logic [31:0] res; logic [4:0] rad; int lat; int st;
    int elat;
    logic [31:0] eres;
    elat = ref_latency(s, a, b);
    eres = ref_result(s, o, a, b);
    run_op(s, o, a, b, ad, got, res, rad, lat, st);
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL %s_pulse: got no result pulse, want one at edge +%0d", name, elat);
    end else begin
      checks++;
      if (res !== eres) begin
        failures++;
        $display("FAIL %s_result: got %h, want %h", name, res, eres);
      end
      checks++;
      if (rad !== ad) begin
        failures++;
        $display("FAIL %s_addr: got %0d, want %0d", name, rad, ad);
      end
      checks++;
      if (lat !== elat) begin
        failures++;
        $display("FAIL %s_latency: got %0d, want %0d", name, lat, elat);
      end
      checks++;
      if (st !== (elat == 0 ? 0 : elat)) begin
        failures++;
        $display("FAIL %s_stall_cycles: got %0d, want %0d", name, st, elat);
      end
    end
    @(posedge clk); #1;
    checks++;
    if ({mul_en_out, stall_because_mul} !== 2'b00) begin
      failures++;
      $display("FAIL %s_one_cycle: got en=%b stall=%b after pulse, want 0 0",
               name, mul_en_out, stall_because_mul);
    end
  endtask

  task automatic test_signed_low();
    test_directed("signed_low", 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 5'd5);
  endtask

  task automatic test_worst_case();
    test_directed("worst_hi", 1'b1, 1'b1, 32'h8000_0000, 32'h8000_0000, 5'd17);
    test_directed("worst_lo", 1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 5'd18);
  endtask

  task automatic test_sign_sensitivity();
    test_directed("unsigned_hi", 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1);
    test_directed("unsigned_lo", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
    test_directed("signed_hi_m1", 1'b1, 1'b1, 32'hFFFF_FFFF, 32'd1, 5'd3);
    test_directed("unsigned_hi_1", 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1, 5'd4);
  endtask

  task automatic test_zero_operand();
    test_directed("zero_b", 1'b0, 1'b0, 32'h1234_5678, 32'd0, 5'd9);
    test_directed("zero_a", 1'b1, 1'b1, 32'd0, 32'hDEAD_BEEF, 5'd10);
  endtask

  task automatic test_flush();
    logic got; logic [31:0] res; logic [4:0] rad; int lat; int st;
    logic spurious;
    mul_sign = 1'b1; mul_op = 1'b1;
    mul_sr0 = 32'h8000_0000; mul_sr1 = 32'h8000_0000; mul_addr_in = 5'd20;
    mul_en_in = 1'b1;
    @(posedge clk); #1;
    mul_en_in = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    mul_flush = 1'b1;  // fifth busy cycle
    @(posedge clk); #1;
    mul_flush = 1'b0;
    checks++;
    if ({mul_en_out, stall_because_mul} !== 2'b00) begin
      failures++;
      $display("FAIL flush_release: got en=%b stall=%b, want 0 0",
               mul_en_out, stall_because_mul);
    end
    run_op(1'b0, 1'b0, 32'd3, 32'd4, 5'd7, got, res, rad, lat, st);
    checks++;
    if (!got || res !== 32'd12 || rad !== 5'd7 || lat !== 3) begin
      failures++;
      $display("FAIL flush_reissue: got pulse=%b res=%h addr=%0d lat=%0d, want 1 0000000c 7 3",
               got, res, rad, lat);
    end
    spurious = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (mul_en_out || stall_because_mul) spurious = 1'b1;
    end
    checks++;
    if (spurious) begin
      failures++;
      $display("FAIL flush_no_late_pulse: got activity after flushed op, want none");
    end
    // Flush and issue together while idle: flush wins.
    mul_sr0 = 32'd5; mul_sr1 = 32'd6; mul_en_in = 1'b1; mul_flush = 1'b1;
    @(posedge clk); #1;
    mul_en_in = 1'b0; mul_flush = 1'b0;
    checks++;
    if ({mul_en_out, stall_because_mul} !== 2'b00) begin
      failures++;
      $display("FAIL flush_idle_priority: got en=%b stall=%b, want 0 0",
               mul_en_out, stall_because_mul);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_op();
    logic spurious;
    mul_sign = 1'b1; mul_op = 1'b0;
    mul_sr0 = 32'h8000_0000; mul_sr1 = 32'h8000_0000; mul_addr_in = 5'd30;
    mul_en_in = 1'b1;
    @(posedge clk); #1;
    mul_en_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({mul_en_out, stall_because_mul, mul_result, mul_addr_out} !== 39'd0) begin
      failures++;
      $display("FAIL reset_mid_outputs: got en=%b stall=%b res=%h addr=%0d, want all 0",
               mul_en_out, stall_because_mul, mul_result, mul_addr_out);
    end
    spurious = 1'b0;
    for (int n = 0; n < 25; n++) begin
      @(posedge clk); #1;
      if (mul_en_out || stall_because_mul) spurious = 1'b1;
    end
    checks++;
    if (spurious) begin
      failures++;
      $display("FAIL reset_mid_no_pulse: got activity after reset, want none");
    end
    test_directed("after_reset", 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 5'd5);
  endtask

  task automatic test_back_to_back();
    logic got; logic [31:0] res; logic [4:0] rad; int lat; int st;
    logic [31:0] a1, b1, a2, b2;
    a1 = 32'h0001_2345; b1 = 32'hFFFF_F00F;
    a2 = 32'hFFFF_FFF0; b2 = 32'h0000_0111;
    run_op(1'b1, 1'b0, a1, b1, 5'd11, got, res, rad, lat, st);
    checks++;
    if (!got || res !== ref_result(1'b1, 1'b0, a1, b1) || rad !== 5'd11) begin
      failures++;
      $display("FAIL b2b_first: got pulse=%b res=%h addr=%0d, want 1 %h 11",
               got, res, rad, ref_result(1'b1, 1'b0, a1, b1));
    end
    // Issue in the same cycle the first result is valid.
    run_op(1'b1, 1'b1, a2, b2, 5'd12, got, res, rad, lat, st);
    checks++;
    if (!got || res !== ref_result(1'b1, 1'b1, a2, b2) || rad !== 5'd12
        || lat !== ref_latency(1'b1, a2, b2)) begin
      failures++;
      $display("FAIL b2b_second: got pulse=%b res=%h addr=%0d lat=%0d, want 1 %h 12 %0d",
               got, res, rad, lat, ref_result(1'b1, 1'b1, a2, b2),
               ref_latency(1'b1, a2, b2));
    end
    // Fast path immediately after.
    run_op(1'b0, 1'b0, 32'd0, 32'd99, 5'd13, got, res, rad, lat, st);
    checks++;
    if (!got || res !== 32'd0 || rad !== 5'd13 || lat !== 0 || st !== 0) begin
      failures++;
      $display("FAIL b2b_fast: got pulse=%b res=%h addr=%0d lat=%0d stall=%0d, want 1 0 13 0 0",
               got, res, rad, lat, st);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic got; logic [31:0] res; logic [4:0] rad; int lat; int st;
    logic s, o;
    logic [31:0] a, b;
    logic [4:0] ad;
    for (int i = 0; i < 60; i++) begin
      s  = 1'($urandom_range(0, 1));
      o  = 1'($urandom_range(0, 1));
      a  = $urandom >> $urandom_range(0, 31);
      b  = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 9) == 0) a = 32'd0;
      if ($urandom_range(0, 9) == 0) b = 32'd0;
      ad = 5'($urandom_range(0, 31));
      run_op(s, o, a, b, ad, got, res, rad, lat, st);
      checks++;
      if (!got || res !== ref_result(s, o, a, b) || rad !== ad
          || lat !== ref_latency(s, a, b) || st !== ref_latency(s, a, b)) begin
        failures++;
        $display("FAIL random_%0d: s=%b o=%b a=%h b=%h got pulse=%b res=%h addr=%0d lat=%0d stall=%0d, want res=%h addr=%0d lat=%0d",
                 i, s, o, a, b, got, res, rad, lat, st, ref_result(s, o, a, b), ad,
                 ref_latency(s, a, b));
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b0; mul_en_in = 1'b0; mul_op = 1'b0; mul_sign = 1'b0;
    mul_sr0 = 32'd0; mul_sr1 = 32'd0; mul_addr_in = 5'd0; mul_flush = 1'b0;
    test_reset();
    test_signed_low();
    test_worst_case();
    test_sign_sensitivity();
    test_zero_operand();
    test_flush();
    test_reset_mid_op();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
